// File: rtl/frv_asi_arbiter.sv
// ============================================================================
// Module   : frv_asi_arbiter
// Brief    : Two-requester arbiter sharing the frv_asi unit between the core
//            execute stage (requester 0) and the crypto coprocessor port
//            (requester 1). Holds the grant until done, flush or timeout.
// Config   : FRV_ASI_ARBITER_RR_EN defined   -> round-robin on contention
//            FRV_ASI_ARBITER_RR_EN undefined -> requester 0 always wins
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module frv_asi_arbiter #(
  parameter int XLEN    = 32,
  parameter int OPW     = 7,    // uop width (OP+1 of the core's uop encoding)
  parameter int TIMEOUT = 15    // 1..15, compared against a 4-bit counter
) (
  input  logic            g_clk,
  input  logic            g_reset,
  // requester 0: core execute stage
  input  logic            req0_valid,
  input  logic            req0_flush,
  input  logic [OPW-1:0]  req0_uop,
  input  logic [XLEN-1:0] req0_rs1,
  input  logic [XLEN-1:0] req0_rs2,
  input  logic [1:0]      req0_shamt,
  output logic            req0_ready,
  output logic            req0_error,
  output logic [XLEN-1:0] req0_result,
  // requester 1: crypto coprocessor port
  input  logic            req1_valid,
  input  logic            req1_flush,
  input  logic [OPW-1:0]  req1_uop,
  input  logic [XLEN-1:0] req1_rs1,
  input  logic [XLEN-1:0] req1_rs2,
  input  logic [1:0]      req1_shamt,
  output logic            req1_ready,
  output logic            req1_error,
  output logic [XLEN-1:0] req1_result,
  // shared frv_asi unit
  output logic            asi_valid,
  output logic            asi_flush,
  output logic [OPW-1:0]  asi_uop,
  output logic [XLEN-1:0] asi_rs1,
  output logic [XLEN-1:0] asi_rs2,
  output logic [1:0]      asi_shamt,
  input  logic            asi_ready,
  input  logic [XLEN-1:0] asi_result
);

  localparam logic [3:0] c_timeout = 4'(TIMEOUT);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t     r_state;
  logic       r_owner;
  logic       r_pref;
  logic [3:0] r_cnt;

  logic w_busy;
  logic w_cand0;
  logic w_cand1;
  logic w_winner;
  logic w_own_valid;
  logic w_own_flush;
  logic w_abort;
  logic w_tmo;
  logic w_done;
  logic w_exit;

  assign w_busy  = (r_state == ST_BUSY);
  assign w_cand0 = req0_valid & ~req0_flush;
  assign w_cand1 = req1_valid & ~req1_flush;

  // A lone candidate wins outright; contention is settled by the pointer.
  assign w_winner = (w_cand0 & ~w_cand1) ? 1'b0 :
                    (w_cand1 & ~w_cand0) ? 1'b1 : r_pref;

  assign w_own_valid = r_owner ? req1_valid : req0_valid;
  assign w_own_flush = r_owner ? req1_flush : req0_flush;

  // Exit causes in strict priority: abandon, then timeout, then completion.
  assign w_abort = w_busy & (w_own_flush | ~w_own_valid);
  assign w_tmo   = w_busy & ~w_abort & (r_cnt == c_timeout);
  assign w_done  = w_busy & ~w_abort & ~w_tmo & asi_ready;
  assign w_exit  = w_abort | w_tmo | w_done;

  // Forward the owner's operation to frv_asi; everything is 0 while idle.
  always_comb begin
    asi_valid = w_busy;
    asi_flush = w_abort | w_tmo;
    asi_uop   = '0;
    asi_rs1   = '0;
    asi_rs2   = '0;
    asi_shamt = '0;
    if (w_busy) begin
      asi_uop   = r_owner ? req1_uop   : req0_uop;
      asi_rs1   = r_owner ? req1_rs1   : req0_rs1;
      asi_rs2   = r_owner ? req1_rs2   : req0_rs2;
      asi_shamt = r_owner ? req1_shamt : req0_shamt;
    end
  end

  // Route the done pulse, error flag and result back to the owner only.
  always_comb begin
    req0_ready  = (w_tmo | w_done) & ~r_owner;
    req0_error  = w_tmo & ~r_owner;
    req0_result = (w_done & ~r_owner) ? asi_result : '0;
    req1_ready  = (w_tmo | w_done) & r_owner;
    req1_error  = w_tmo & r_owner;
    req1_result = (w_done & r_owner) ? asi_result : '0;
  end

  // Grant/hold state machine with the watchdog counter and fairness pointer.
  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      r_state <= ST_IDLE;
      r_owner <= 1'b0;
      r_pref  <= 1'b0;
      r_cnt   <= 4'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_cand0 | w_cand1) begin
            r_owner <= w_winner;
            r_state <= ST_BUSY;
            r_cnt   <= 4'd0;
          end
        end
        ST_BUSY: begin
          if (w_exit) begin
            r_state <= ST_IDLE;
`ifdef FRV_ASI_ARBITER_RR_EN
            r_pref  <= ~r_owner;
`else
            r_pref  <= 1'b0;
`endif
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_frv_asi_arbiter.sv
// ============================================================================
// Module   : tb_frv_asi_arbiter
// Brief    : Self-checking bench for frv_asi_arbiter. Per-cycle vector table
//            plus hand sequences for watchdog timeout and mid-operation reset.
//            Expectations follow FRV_ASI_ARBITER_RR_EN when it is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_frv_asi_arbiter;

  localparam int XLEN = 32;
  localparam int OPW  = 7;

`ifdef FRV_ASI_ARBITER_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  localparam logic [OPW-1:0]  U0   = 7'h13;
  localparam logic [XLEN-1:0] A0   = 32'h1;
  localparam logic [XLEN-1:0] B0   = 32'h2;
  localparam logic [1:0]      SH0  = 2'd1;
  localparam logic [OPW-1:0]  U1   = 7'h55;
  localparam logic [XLEN-1:0] A1   = 32'h10;
  localparam logic [XLEN-1:0] B1   = 32'h20;
  localparam logic [1:0]      SH1  = 2'd2;
  // frv_asi stand-in computes rs1+rs2, so these are the per-owner results
  localparam logic [XLEN-1:0] RES0 = 32'h3;
  localparam logic [XLEN-1:0] RES1 = 32'h30;

  logic            clk = 1'b0;
  logic            g_reset = 1'b1;
  logic            req0_valid = 1'b0, req0_flush = 1'b0;
  logic            req1_valid = 1'b0, req1_flush = 1'b0;
  logic [OPW-1:0]  req0_uop, req1_uop;
  logic [XLEN-1:0] req0_rs1, req0_rs2, req1_rs1, req1_rs2;
  logic [1:0]      req0_shamt, req1_shamt;
  logic            req0_ready, req0_error, req1_ready, req1_error;
  logic [XLEN-1:0] req0_result, req1_result;
  logic            asi_valid, asi_flush, asi_ready;
  logic [OPW-1:0]  asi_uop;
  logic [XLEN-1:0] asi_rs1, asi_rs2, asi_result;
  logic [1:0]      asi_shamt;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  assign asi_result = asi_rs1 + asi_rs2;

  frv_asi_arbiter #(.XLEN(XLEN), .OPW(OPW), .TIMEOUT(15)) dut (
    .g_clk(clk), .g_reset(g_reset),
    .req0_valid(req0_valid), .req0_flush(req0_flush), .req0_uop(req0_uop),
    .req0_rs1(req0_rs1), .req0_rs2(req0_rs2), .req0_shamt(req0_shamt),
    .req0_ready(req0_ready), .req0_error(req0_error), .req0_result(req0_result),
    .req1_valid(req1_valid), .req1_flush(req1_flush), .req1_uop(req1_uop),
    .req1_rs1(req1_rs1), .req1_rs2(req1_rs2), .req1_shamt(req1_shamt),
    .req1_ready(req1_ready), .req1_error(req1_error), .req1_result(req1_result),
    .asi_valid(asi_valid), .asi_flush(asi_flush), .asi_uop(asi_uop),
    .asi_rs1(asi_rs1), .asi_rs2(asi_rs2), .asi_shamt(asi_shamt),
    .asi_ready(asi_ready), .asi_result(asi_result)
  );

  // in: {rst, r0v, r0f, r1v, r1f, asi_ready}
  // ex: {asi_valid, asi_flush, r0_ready, r0_error, r1_ready, r1_error}
  // fw: 0 = nothing forwarded, 1 = req0 operands, 2 = req1 operands
  typedef struct {
    bit [5:0]        in;
    bit [5:0]        ex;
    bit [1:0]        fw;
    logic [XLEN-1:0] r0;
    logic [XLEN-1:0] r1;
  } vec_t;

  localparam int NV = 27;
  vec_t tbl [NV];

  task automatic check(input string name, input bit [5:0] ex, input bit [1:0] fw,
                       input logic [XLEN-1:0] r0, input logic [XLEN-1:0] r1);
    logic [142:0] act, exp;
    logic [OPW-1:0]  eu;
    logic [XLEN-1:0] ea, eb;
    logic [1:0]      es;
    eu = '0; ea = '0; eb = '0; es = '0;
    if (fw == 2'd1) begin eu = U0; ea = A0; eb = B0; es = SH0; end
    if (fw == 2'd2) begin eu = U1; ea = A1; eb = B1; es = SH1; end
    act = {asi_valid, asi_flush, asi_uop, asi_rs1, asi_rs2, asi_shamt,
           req0_ready, req0_error, req0_result, req1_ready, req1_error, req1_result};
    exp = {ex[5], ex[4], eu, ea, eb, es, ex[3], ex[2], r0, ex[1], ex[0], r1};
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Apply one cycle of inputs after the falling edge, then check outputs.
  task automatic step(input string name, input bit [5:0] in, input bit [5:0] ex,
                      input bit [1:0] fw, input logic [XLEN-1:0] r0,
                      input logic [XLEN-1:0] r1);
    @(negedge clk);
    g_reset    = in[5];
    req0_valid = in[4];
    req0_flush = in[3];
    req1_valid = in[2];
    req1_flush = in[1];
    asi_ready  = in[0];
    #1;
    check(name, ex, fw, r0, r1);
  endtask

  initial begin
    req0_uop = U0; req0_rs1 = A0; req0_rs2 = B0; req0_shamt = SH0;
    req1_uop = U1; req1_rs1 = A1; req1_rs2 = B1; req1_shamt = SH1;
    asi_ready = 1'b0;

    // reset, then a single-cycle req0 op
    tbl[0]  = '{6'b100000, 6'b000000, 2'd0, 32'h0, 32'h0};
    tbl[1]  = '{6'b010000, 6'b000000, 2'd0, 32'h0, 32'h0};
    tbl[2]  = '{6'b010001, 6'b101000, 2'd1, RES0,  32'h0};
    tbl[3]  = '{6'b000000, 6'b000000, 2'd0, 32'h0, 32'h0};
    // both requesters always valid, single-cycle ops
    tbl[4]  = '{6'b100000, 6'b000000, 2'd0, 32'h0, 32'h0};
    tbl[5]  = '{6'b010101, 6'b000000, 2'd0, 32'h0, 32'h0};
    tbl[6]  = '{6'b010101, 6'b101000, 2'd1, RES0,  32'h0};
    tbl[7]  = '{6'b010101, 6'b000000, 2'd0, 32'h0, 32'h0};
    tbl[8]  = '{6'b010101, RR ? 6'b100010 : 6'b101000, RR ? 2'd2 : 2'd1,
                RR ? 32'h0 : RES0, RR ? RES1 : 32'h0};
    tbl[9]  = '{6'b010101, 6'b000000, 2'd0, 32'h0, 32'h0};
    tbl[10] = '{6'b010101, 6'b101000, 2'd1, RES0,  32'h0};
    tbl[11] = '{6'b010101, 6'b000000, 2'd0, 32'h0, 32'h0};
    tbl[12] = '{6'b010101, RR ? 6'b100010 : 6'b101000, RR ? 2'd2 : 2'd1,
                RR ? 32'h0 : RES0, RR ? RES1 : 32'h0};
    // req1 multi-cycle op: three waiting cycles, done in the 4th
    tbl[13] = '{6'b000100, 6'b000000, 2'd0, 32'h0, 32'h0};
    tbl[14] = '{6'b000100, 6'b100000, 2'd2, 32'h0, 32'h0};
    tbl[15] = '{6'b000100, 6'b100000, 2'd2, 32'h0, 32'h0};
    tbl[16] = '{6'b000100, 6'b100000, 2'd2, 32'h0, 32'h0};
    tbl[17] = '{6'b000101, 6'b100010, 2'd2, 32'h0, RES1};
    tbl[18] = '{6'b000000, 6'b000000, 2'd0, 32'h0, 32'h0};
    // req0 flushed in 2nd BUSY cycle with asi_ready high; req1 then granted
    tbl[19] = '{6'b010100, 6'b000000, 2'd0, 32'h0, 32'h0};
    tbl[20] = '{6'b010100, 6'b100000, 2'd1, 32'h0, 32'h0};
    tbl[21] = '{6'b011101, 6'b110000, 2'd1, 32'h0, 32'h0};
    tbl[22] = '{6'b000100, 6'b000000, 2'd0, 32'h0, 32'h0};
    tbl[23] = '{6'b000101, 6'b100010, 2'd2, 32'h0, RES1};
    tbl[24] = '{6'b000000, 6'b000000, 2'd0, 32'h0, 32'h0};
    // flush together with the request: no grant follows
    tbl[25] = '{6'b011000, 6'b000000, 2'd0, 32'h0, 32'h0};
    tbl[26] = '{6'b000000, 6'b000000, 2'd0, 32'h0, 32'h0};

    for (int i = 0; i < NV; i++)
      step($sformatf("row%0d", i), tbl[i].in, tbl[i].ex, tbl[i].fw, tbl[i].r0, tbl[i].r1);

    // watchdog: 15 waiting cycles, abort in BUSY cycle 16 even with asi_ready
    step("tmo_grant", 6'b010000, 6'b000000, 2'd0, 32'h0, 32'h0);
    for (int k = 1; k <= 15; k++)
      step($sformatf("tmo_wait%0d", k), 6'b010000, 6'b100000, 2'd1, 32'h0, 32'h0);
    step("tmo_abort", 6'b010001, 6'b111100, 2'd1, 32'h0, 32'h0);
    step("tmo_idle", 6'b000000, 6'b000000, 2'd0, 32'h0, 32'h0);

    // reset mid-BUSY: outputs drop at once, no ready pulse, pref back to 0
    step("rst_grant", 6'b000100, 6'b000000, 2'd0, 32'h0, 32'h0);
    step("rst_busy", 6'b000100, 6'b100000, 2'd2, 32'h0, 32'h0);
    #2;
    g_reset   = 1'b1;
    asi_ready = 1'b1;
    #1;
    check("rst_async", 6'b000000, 2'd0, 32'h0, 32'h0);
    step("rst_held", 6'b100101, 6'b000000, 2'd0, 32'h0, 32'h0);
    step("rst_regrant", 6'b010100, 6'b000000, 2'd0, 32'h0, 32'h0);
    step("rst_owner0", 6'b010101, 6'b101000, 2'd1, RES0, 32'h0);
    step("rst_idle", 6'b000000, 6'b000000, 2'd0, 32'h0, 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
